// File: rtl/elevator_pkg.sv
// Shared constants, state encoding and SCAN helpers for the elevator call panel.
package elevator_pkg;

    localparam int unsigned NFLR = 3;

    localparam logic [NFLR-1:0] F1 = 3'b001;
    localparam logic [NFLR-1:0] F2 = 3'b010;
    localparam logic [NFLR-1:0] F3 = 3'b100;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DOOR  = 2'd2
    } panel_state_e;

    // Nearest pending floor strictly above the current floor, one-hot or zero.
    function automatic logic [NFLR-1:0] scan_up(input logic [NFLR-1:0] pend,
                                                input logic [NFLR-1:0] cur);
        logic [NFLR-1:0] r;
        r = '0;
        case (cur)
            F1: begin
                if (pend[1])      r = F2;
                else if (pend[2]) r = F3;
            end
            F2: if (pend[2]) r = F3;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Nearest pending floor strictly below the current floor, one-hot or zero.
    function automatic logic [NFLR-1:0] scan_down(input logic [NFLR-1:0] pend,
                                                  input logic [NFLR-1:0] cur);
        logic [NFLR-1:0] r;
        r = '0;
        case (cur)
            F3: begin
                if (pend[1])      r = F2;
                else if (pend[0]) r = F1;
            end
            F2: if (pend[0]) r = F1;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/elevator_call_panel_if.sv
// Request/status bundle between the call panel (master) and the elevator controller.
interface elevator_call_panel_if;
    logic [3:1] Req;
    logic       FLR1;
    logic       FLR2;
    logic       FLR3;
    logic       Door;

    modport master (output Req, input FLR1, FLR2, FLR3, Door);
    modport slave  (input Req, output FLR1, FLR2, FLR3, Door);
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-FF synchronizer, stability counter and rising-edge press pulse.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned DEB_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    // Count consecutive samples that disagree with the accepted level; accept on the last.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) level_d = sync2_q;
            else                   cnt_d   = cnt_q + DEB_W'(1);
        end
        press_d = level_d & ~level_q;
    end

    // Synchronizer, debounce state and registered press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/elevator_call_panel.sv
// Call panel: debounced buttons, pending-call latch, SCAN target choice, one-hot Req.
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned DEB_W      = 8
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic [3:1]                   Btn,
    elevator_call_panel_if.master        ctl,
    output logic [3:1]                   CallLamp,
    output logic                         Dir
);

    logic [NFLR-1:0] press;
    panel_state_e    state_q, state_d;
    logic [NFLR-1:0] tgt_q, tgt_d;
    logic [NFLR-1:0] req_q, req_d;
    logic [NFLR-1:0] pend_q, pend_d;
    logic [NFLR-1:0] cur_q, cur_d;
    logic            dir_q, dir_d;
    logic [NFLR-1:0] flr_c, up_c, dn_c, sel_c, clr_c, drop_c;
    logic            sel_dir_c;

    for (genvar g = 0; g < NFLR; g++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .DEB_W      (DEB_W)
        ) u_deb (
            .clk     (clk),
            .rst_n   (Reset),
            .btn_i   (Btn[g+1]),
            .press_o (press[g])
        );
    end

    // Current floor follows the controller only when exactly one floor flag is up.
    always_comb begin
        flr_c = {ctl.FLR3, ctl.FLR2, ctl.FLR1};
        cur_d = cur_q;
        case (flr_c)
            F1, F2, F3: cur_d = flr_c;
            default:    cur_d = cur_q;
        endcase
    end

    // SCAN choice: here first, then ahead in Dir, else reverse and flip Dir.
    always_comb begin
        up_c      = scan_up(pend_q, cur_d);
        dn_c      = scan_down(pend_q, cur_d);
        sel_c     = '0;
        sel_dir_c = dir_q;
        if ((pend_q & cur_d) != '0) begin
            sel_c = cur_d;
        end else if (dir_q == UP) begin
            if (up_c != '0) sel_c = up_c;
            else begin
                sel_c     = dn_c;
                sel_dir_c = DOWN;
            end
        end else begin
            if (dn_c != '0) sel_c = dn_c;
            else begin
                sel_c     = up_c;
                sel_dir_c = UP;
            end
        end
    end

    // Panel FSM next state, request and pending-set update (service clear beats a press).
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        req_d   = '0;
        dir_d   = dir_q;
        clr_c   = '0;
        drop_c  = '0;
        case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    tgt_d   = sel_c;
                    dir_d   = sel_dir_c;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                req_d = tgt_q;
                if (ctl.Door && (cur_d == tgt_q)) begin
                    clr_c   = tgt_q;
                    req_d   = '0;
                    state_d = DOOR;
                end
            end
            DOOR: begin
                drop_c = cur_d;
                if (!ctl.Door) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        pend_d = (pend_q | (press & ~drop_c)) & ~clr_c;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            req_q   <= '0;
            pend_q  <= '0;
            cur_q   <= F1;
            dir_q   <= UP;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            dir_q   <= dir_d;
        end
    end

    assign ctl.Req  = req_q;
    assign CallLamp = pend_q;
    assign Dir      = dir_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel with DEB_CYCLES=4 (press-to-lamp 7 cycles).
module tb_elevator_call_panel;

    logic       clk = 1'b0;
    logic       Reset;
    logic [3:1] Btn;
    logic [3:1] CallLamp;
    logic       Dir;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    elevator_call_panel_if ctl_if ();

    elevator_call_panel #(
        .DEB_CYCLES (4),
        .DEB_W      (8)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .Btn      (Btn),
        .ctl      (ctl_if),
        .CallLamp (CallLamp),
        .Dir      (Dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_flr(input logic [3:1] f);
        ctl_if.FLR1 = f[1];
        ctl_if.FLR2 = f[2];
        ctl_if.FLR3 = f[3];
    endtask

    initial begin
        Reset       = 1'b0;
        Btn         = 3'b000;
        ctl_if.Door = 1'b0;
        set_flr(3'b001);

        // Reset values
        #7;
        chk("rst_req",  8'(ctl_if.Req), 8'h00);
        chk("rst_lamp", 8'(CallLamp),   8'h00);
        chk("rst_dir",  8'(Dir),        8'h01);
        tick(2);
        Reset = 1'b1;
        tick(2);

        // Bounce rejection on floor 2, then stable high
        for (int i = 0; i < 5; i++) begin
            Btn[2] = 1'b1; tick(2);
            Btn[2] = 1'b0; tick(2);
        end
        chk("bnc_quiet", 8'(CallLamp), 8'h00);
        Btn[2] = 1'b1;
        tick(6);
        chk("bnc_early", 8'(CallLamp), 8'h00);
        tick(1);
        chk("bnc_set", 8'(CallLamp), 8'h02);
        tick(2);
        chk("bnc_req", 8'(ctl_if.Req), 8'h02);
        Btn[2] = 1'b0;
        set_flr(3'b010);
        ctl_if.Door = 1'b1;
        tick(1);
        chk("bnc_svc_req",  8'(ctl_if.Req), 8'h00);
        chk("bnc_svc_lamp", 8'(CallLamp),   8'h00);
        ctl_if.Door = 1'b0;
        set_flr(3'b001);
        tick(8);

        // Single call: at floor 1, call floor 3
        Btn[3] = 1'b1;
        tick(7);
        chk("one_lamp", 8'(CallLamp), 8'h04);
        tick(1);
        chk("one_lat", 8'(ctl_if.Req), 8'h00);
        tick(1);
        chk("one_req", 8'(ctl_if.Req), 8'h04);
        chk("one_dir", 8'(Dir), 8'h01);
        Btn[3] = 1'b0;
        set_flr(3'b100);
        ctl_if.Door = 1'b1;
        tick(1);
        chk("one_svc_req",  8'(ctl_if.Req), 8'h00);
        chk("one_svc_lamp", 8'(CallLamp),   8'h00);
        ctl_if.Door = 1'b0;
        tick(8);
        chk("one_idle", 8'(ctl_if.Req), 8'h00);

        // SCAN: at floor 2 going up, calls on 1 and 3
        set_flr(3'b010);
        Btn[1] = 1'b1;
        Btn[3] = 1'b1;
        tick(7);
        chk("scan_lamp", 8'(CallLamp), 8'h05);
        tick(2);
        chk("scan_req3", 8'(ctl_if.Req), 8'h04);
        chk("scan_dir3", 8'(Dir), 8'h01);
        Btn = 3'b000;
        set_flr(3'b100);
        ctl_if.Door = 1'b1;
        tick(1);
        chk("scan_svc3_req",  8'(ctl_if.Req), 8'h00);
        chk("scan_svc3_lamp", 8'(CallLamp),   8'h01);
        ctl_if.Door = 1'b0;
        tick(3);
        chk("scan_req1", 8'(ctl_if.Req), 8'h01);
        chk("scan_dir1", 8'(Dir), 8'h00);
        set_flr(3'b001);
        ctl_if.Door = 1'b1;
        tick(1);
        chk("scan_svc1_req",  8'(ctl_if.Req), 8'h00);
        chk("scan_svc1_lamp", 8'(CallLamp),   8'h00);
        ctl_if.Door = 1'b0;
        tick(2);

        // Same-floor call, then a press during door-open is dropped
        Btn[1] = 1'b1;
        tick(7);
        chk("same_lamp", 8'(CallLamp), 8'h01);
        tick(2);
        chk("same_req", 8'(ctl_if.Req), 8'h01);
        Btn[1] = 1'b0;
        ctl_if.Door = 1'b1;
        tick(1);
        chk("same_svc_req",  8'(ctl_if.Req), 8'h00);
        chk("same_svc_lamp", 8'(CallLamp),   8'h00);
        tick(6);
        Btn[1] = 1'b1;
        tick(7);
        chk("drop_lamp_a", 8'(CallLamp), 8'h00);
        tick(1);
        chk("drop_lamp_b", 8'(CallLamp), 8'h00);
        Btn[1] = 1'b0;
        ctl_if.Door = 1'b0;
        tick(2);
        chk("drop_idle", 8'(ctl_if.Req), 8'h00);
        tick(6);

        // Floor 2 pending while going down from floor 1: Dir flips up
        Btn[2] = 1'b1;
        tick(7);
        chk("sim_pre_lamp", 8'(CallLamp), 8'h02);
        tick(2);
        chk("sim_pre_req", 8'(ctl_if.Req), 8'h02);
        chk("sim_pre_dir", 8'(Dir), 8'h01);
        Btn[2] = 1'b0;
        tick(7);

        // Press 1 and 2 together; floor-2 press lands on the service cycle
        Btn[1] = 1'b1;
        Btn[2] = 1'b1;
        tick(6);
        chk("sim_hold_lamp", 8'(CallLamp),   8'h02);
        chk("sim_hold_req",  8'(ctl_if.Req), 8'h02);
        set_flr(3'b010);
        ctl_if.Door = 1'b1;
        tick(1);
        chk("sim_lamp", 8'(CallLamp),   8'h01);
        chk("sim_req",  8'(ctl_if.Req), 8'h00);
        Btn = 3'b000;
        ctl_if.Door = 1'b0;
        tick(3);
        chk("sim_next_req", 8'(ctl_if.Req), 8'h01);
        chk("sim_next_dir", 8'(Dir), 8'h00);

        // Asynchronous reset mid-ISSUE
        #1 Reset = 1'b0;
        #1;
        chk("arst_req",  8'(ctl_if.Req), 8'h00);
        chk("arst_lamp", 8'(CallLamp),   8'h00);
        chk("arst_dir",  8'(Dir),        8'h01);
        tick(2);
        Reset = 1'b1;
        tick(3);
        chk("post_rst_req",  8'(ctl_if.Req), 8'h00);
        chk("post_rst_lamp", 8'(CallLamp),   8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
